// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor and its instruction sequencer:
// opcodes, sequencer state encoding and the machine word width.
package proc_pkg;

    localparam int WORD_W = 9;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_IMM   = 3'd3,
        ST_WAIT  = 3'd4
    } seq_state_e;

    // Opcodes the processor can execute; HALT and 100-110 are never issued.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches words from a synchronous ROM and feeds the
// processor one instruction at a time, waiting for Done between instructions.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WDOG   = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [WORD_W-1:0] MemData,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        InstrCount
);

    localparam int WD_W = $clog2(WDOG + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        op_q, op_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              stop_q, stop_d;

    logic [ADDR_W-1:0] pc_inc_s;
    logic [WD_W-1:0]   wdog_inc_s;
    logic [2:0]        cur_op_s;

    assign pc_inc_s   = pc_q + ADDR_W'(1);
    assign wdog_inc_s = wdog_q + WD_W'(1);
    assign cur_op_s   = MemData[WORD_W-1:WORD_W-3];

    // Next-state logic and the outputs decoded from state and ROM data.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        halted_d = halted_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        stop_d   = stop_q;
        MemAddr  = pc_q;
        Run      = 1'b0;
        DIN      = '0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                    cnt_d    = 8'd0;
                    wdog_d   = '0;
                    stop_d   = Stop;
                    state_d  = ST_FETCH;
                end else begin
                    stop_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                stop_d  = stop_q | Stop;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cur_op_s == OP_HALT) begin
                    halted_d = 1'b1;
                    stop_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (!op_is_legal(cur_op_s)) begin
                    error_d  = 1'b1;
                    stop_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    Run      = 1'b1;
                    DIN      = MemData;
                    MemAddr  = pc_inc_s;
                    op_d     = cur_op_s;
                    wdog_d   = '0;
                    stop_d   = stop_q | Stop;
                    state_d  = (cur_op_s == OP_MVI) ? ST_IMM : ST_WAIT;
                end
            end
            ST_IMM: begin
                DIN     = MemData;
                MemAddr = pc_inc_s;
                stop_d  = stop_q | Stop;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (Done) begin
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    pc_d    = (op_q == OP_MVI) ? pc_q + ADDR_W'(2) : pc_inc_s;
                    stop_d  = 1'b0;
                    state_d = (stop_q | Stop) ? ST_IDLE : ST_FETCH;
                end else if (wdog_inc_s == WD_W'(WDOG)) begin
                    wdog_d  = wdog_inc_s;
                    error_d = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d  = wdog_inc_s;
                    stop_d  = stop_q | Stop;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                stop_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            op_q     <= 3'b000;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= 8'd0;
            wdog_q   <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            stop_q   <= stop_d;
        end
    end

    assign Busy       = (state_q != ST_IDLE);
    assign Halted     = halted_q;
    assign Error      = error_q;
    assign PC         = pc_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: a program-level reference model predicts
// every issued word, immediate, timing gap and final status of each run.
module tb_proc_sequencer;
    import proc_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int WD    = 4;

    logic          Clock = 1'b0;
    logic          Reset, Start, Stop, Run, Done, Busy, Halted, Error;
    logic [AW-1:0] MemAddr, PC;
    logic [8:0]    MemData, DIN;
    logic [7:0]    InstrCount;

    proc_sequencer #(.ADDR_W(AW), .WDOG(WD)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
        .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run),
        .Done(Done), .Busy(Busy), .Halted(Halted), .Error(Error),
        .PC(PC), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    logic [8:0] rom [DEPTH];
    always @(posedge Clock) MemData <= rom[MemAddr];

    // Processor model: Done pulses lat_arr[n] cycles after the n-th Run edge.
    int         lat_arr [512];
    int         p_n, p_t, p_lat;
    logic       p_act;
    logic [8:0] p_ir, p_imm;
    logic [8:0] regs [8];

    assign Done = p_act && (p_t == p_lat);

    always @(posedge Clock) begin
        if (Reset) begin
            p_act <= 1'b0; p_n <= 0; p_t <= 0; p_lat <= 0;
            for (int i = 0; i < 8; i++) regs[i] <= 9'd0;
        end else if (Start && !Busy) begin
            p_n <= 0; p_act <= 1'b0;
        end else if (Run) begin
            p_act <= 1'b1; p_ir <= DIN; p_t <= 1; p_lat <= lat_arr[p_n]; p_n <= p_n + 1;
        end else if (p_act) begin
            if (p_t == 1 && p_ir[8:6] == 3'b001) p_imm <= DIN;
            if (Done) begin
                p_act <= 1'b0;
                case (p_ir[8:6])
                    3'b000:  regs[p_ir[5:3]] <= regs[p_ir[2:0]];
                    3'b001:  regs[p_ir[5:3]] <= p_imm;
                    3'b010:  regs[p_ir[5:3]] <= regs[p_ir[5:3]] + regs[p_ir[2:0]];
                    3'b011:  regs[p_ir[5:3]] <= regs[p_ir[5:3]] - regs[p_ir[2:0]];
                    default: ;
                endcase
            end else begin
                p_t <= p_t + 1;
            end
        end
    end

    typedef struct {
        bit         fin;
        logic [8:0] din;
        logic [8:0] imm;
        bit         mvi;
        int         gap;
        int         halted;
        int         error;
        int         pc;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_fin(input int gap, input int h, input int e, input int pc, input int cnt);
        exp_t x;
        x.fin = 1'b1; x.din = 9'd0; x.imm = 9'd0; x.mvi = 1'b0;
        x.gap = gap; x.halted = h; x.error = e; x.pc = pc; x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    // Reference model: walk the program as the specification describes it.
    // Times are in cycles with the first FETCH at 0.
    task automatic build_expect(input int stop_at, input int extra_max);
        int pc, cnt, issue, t_prev, waits, mvi;
        logic [8:0] w;
        exp_t x;
        pc = 0; cnt = 0; issue = 1; t_prev = 0;
        for (int n = 0; n < 400; n++) begin
            w = rom[pc];
            if (w[8:6] == 3'b111) begin
                push_fin(issue + 1 - t_prev, 1, 0, pc, cnt); return;
            end
            if (w[8:6] >= 3'b100) begin
                push_fin(issue + 1 - t_prev, 0, 1, pc, cnt); return;
            end
            mvi = (w[8:6] == 3'b001) ? 1 : 0;
            x.fin = 1'b0; x.din = w; x.imm = rom[(pc + 1) % DEPTH]; x.mvi = (mvi == 1);
            x.gap = issue - t_prev; x.halted = 0; x.error = 0; x.pc = 0; x.cnt = 0;
            exp_q.push_back(x);
            t_prev = issue;
            if (lat_arr[n] < 0)
                lat_arr[n] = ((w[8:6] == 3'b010 || w[8:6] == 3'b011) ? 4 : 2)
                             + $urandom_range(extra_max, 0);
            waits = lat_arr[n] - mvi;
            if (waits < 1 || waits > WD) begin
                push_fin(mvi + WD + 1, 0, 1, pc, cnt); return;
            end
            cnt = (cnt < 255) ? cnt + 1 : 255;
            pc  = (pc + 1 + mvi) % DEPTH;
            if (n == stop_at) begin
                push_fin(mvi + waits + 1, 0, 0, pc, cnt); return;
            end
            issue = issue + mvi + waits + 2;
        end
    endtask

    // Monitor: samples one time unit after each rising edge.
    int         cyc = 0, prev = 0;
    bit         busy_p = 1'b0, imm_pend = 1'b0;
    logic [8:0] imm_exp;

    always @(posedge Clock) begin
        exp_t e;
        #1;
        cyc++;
        if (Reset) begin
            imm_pend = 1'b0;
        end else begin
            if (imm_pend) begin
                check("imm_din", DIN, imm_exp);
                imm_pend = 1'b0;
            end
            if (Busy && !busy_p) prev = cyc;
            if (Run) begin
                if (exp_q.size() == 0 || exp_q[0].fin) begin
                    check("unexpected_run", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_din", DIN, e.din);
                    check("issue_gap", cyc - prev, e.gap);
                    prev = cyc;
                    if (e.mvi) begin imm_pend = 1'b1; imm_exp = e.imm; end
                end
            end
            if (!Busy && busy_p) begin
                if (exp_q.size() == 0 || !exp_q[0].fin) begin
                    check("unexpected_end", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("end_gap", cyc - prev, e.gap);
                    check("end_halted", Halted, e.halted);
                    check("end_error", Error, e.error);
                    check("end_pc", PC, e.pc);
                    check("end_count", InstrCount, e.cnt);
                end
            end
        end
        busy_p = Busy;
    end

    task automatic clear_lat();
        for (int i = 0; i < 512; i++) lat_arr[i] = -1;
    endtask

    task automatic fill_rom(input logic [8:0] w);
        for (int i = 0; i < DEPTH; i++) rom[i] = w;
    endtask

    // mode: 0 none, 1 Stop with Start, 2 Stop at Run of instr k,
    // 3 Stop while instr k has Done high, 4 lone Stop pulse in IDLE.
    task automatic run_test(input int mode, input int stop_at, input int extra_max);
        int runs, waited;
        bit stop_done;
        build_expect((mode == 1) ? 0 : ((mode == 2 || mode == 3) ? stop_at : -1), extra_max);
        @(negedge Clock);
        if (mode == 4) begin
            Stop = 1'b1; @(negedge Clock); Stop = 1'b0; @(negedge Clock);
        end
        Start = 1'b1; Stop = (mode == 1);
        @(negedge Clock);
        Start = 1'b0; Stop = 1'b0;
        runs = 0; waited = 0; stop_done = 1'b0;
        while (waited < 4000) begin
            if (Stop) Stop = 1'b0;
            if (Run) runs++;
            if (!stop_done && runs == stop_at + 1) begin
                if ((mode == 2 && Run) || (mode == 3 && Done)) begin
                    Stop = 1'b1; stop_done = 1'b1;
                end
            end
            if (!Busy) break;
            @(negedge Clock);
            waited++;
        end
        Stop = 1'b0;
        if (waited >= 4000) check("run_timeout", waited, 0);
        @(negedge Clock);
        @(negedge Clock);
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [2:0] op;
        int r, waited;
        Reset = 1'b1; Start = 1'b0; Stop = 1'b0;
        clear_lat();
        fill_rom(9'o700);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_busy", Busy, 0);
        check("rst_run", Run, 0);
        check("rst_din", DIN, 0);
        check("rst_memaddr", MemAddr, 0);
        check("rst_pc", PC, 0);
        check("rst_halted", Halted, 0);
        check("rst_error", Error, 0);
        check("rst_count", InstrCount, 0);

        // MVI R0,5 then HALT
        fill_rom(9'o700); clear_lat();
        rom[0] = 9'o100; rom[1] = 9'd5; rom[2] = 9'o700;
        run_test(0, -1, 0);
        check("t1_halted", Halted, 1);
        check("t1_pc", PC, 2);
        check("t1_count", InstrCount, 1);

        // MVI R0,3; MVI R1,4; ADD R0,R1; MV R2,R0; HALT
        fill_rom(9'o700); clear_lat();
        rom[0] = 9'o100; rom[1] = 9'd3; rom[2] = 9'o110; rom[3] = 9'd4;
        rom[4] = 9'o201; rom[5] = 9'o020; rom[6] = 9'o700;
        run_test(0, -1, 0);
        check("prog_r2", regs[2], 7);
        check("prog_count", InstrCount, 4);

        // Illegal opcodes
        for (int k = 4; k <= 6; k++) begin
            fill_rom(9'o700); clear_lat();
            rom[0] = 9'(k * 64);
            run_test(0, -1, 0);
            check("illegal_error", Error, 1);
        end

        // Done never returns
        fill_rom(9'o700); clear_lat();
        rom[0] = 9'o201; lat_arr[0] = 0;
        run_test(0, -1, 0);
        check("wdog_error", Error, 1);

        // Stop during ADD, Stop with Done, Start+Stop, Stop in IDLE
        fill_rom(9'o700); clear_lat();
        rom[0] = 9'o201; rom[1] = 9'o000; rom[2] = 9'o311;
        run_test(2, 0, 0);
        check("stop_add_pc", PC, 1);
        clear_lat();
        run_test(3, 1, 0);
        check("stop_done_pc", PC, 2);
        clear_lat();
        run_test(1, 0, 0);
        check("start_stop_count", InstrCount, 1);
        clear_lat();
        run_test(4, -1, 0);
        check("idle_stop_halted", Halted, 1);

        // PC wrap with MVI at the last address
        fill_rom(9'o000); clear_lat();
        rom[0] = 9'o012; rom[DEPTH-1] = 9'o110;
        run_test(2, 32, 0);
        check("wrap_pc", PC, 2);

        // Instruction count saturation
        fill_rom(9'o000); clear_lat();
        run_test(2, 259, 0);
        check("sat_count", InstrCount, 255);

        // Randomised programs and latencies
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(99, 0);
                if (r < 6) op = 3'b111;
                else if (r < 12) op = 3'($urandom_range(6, 4));
                else op = 3'($urandom_range(3, 0));
                rom[i] = {op, 6'($urandom)};
            end
            clear_lat();
            run_test(($urandom_range(9, 0) == 0) ? 1 : $urandom_range(3, 2),
                     $urandom_range(15, 0), $urandom_range(2, 0));
        end

        // Reset asserted in IMM
        fill_rom(9'o700); clear_lat();
        rom[0] = 9'o100; rom[1] = 9'd9;
        build_expect(-1, 0);
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        waited = 0;
        while (!Run && waited < 20) begin @(negedge Clock); waited++; end
        check("rst_imm_reached_issue", Run, 1);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_imm_run", Run, 0);
        check("rst_imm_busy", Busy, 0);
        check("rst_imm_pc", PC, 0);
        Reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
